// File: rtl/dm_responder.sv
// dm_responder: single-outstanding data-memory responder.
// Accepts a request in IDLE, waits WAIT_CYCLES edges, commits byte-lane
// writes to a word array and returns the addressed word with a one-cycle ack.
module dm_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [3:0]  wea,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err,
  output logic        busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  localparam int        DEPTH    = 2 ** ADDR_WIDTH;
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  logic [1:0]  r_state;
  logic [3:0]  r_cnt;
  logic [3:0]  r_wea;
  logic [29:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;

  logic [31:0] r_mem [DEPTH];

  logic [ADDR_WIDTH-1:0] w_idx;
  logic                  w_in_range;
  logic                  w_commit;
  logic [31:0]           w_old;
  logic [31:0]           w_merged;
  logic                  w_unused;

  // Byte-address LSBs never select anything: the array is word-granular.
  assign w_unused   = ^addr[1:0];

  assign w_idx      = r_addr[ADDR_WIDTH-1:0];
  assign w_in_range = (r_addr[29:ADDR_WIDTH] == '0);
  assign w_commit   = (r_state == S_WAIT) && (r_cnt == 4'd0);
  assign w_old      = r_mem[w_idx];

  // Merge new lanes over the stored word; this is both the write value and the returned word.
  always_comb begin
    w_merged = w_old;
    for (int i = 0; i < 4; i++) begin
      if (r_wea[i]) w_merged[8*i +: 8] = r_wdata[8*i +: 8];
    end
  end

  // Control FSM, request capture and response registers; reset wins over a commit on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_wea   <= 4'd0;
      r_addr  <= 30'd0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_wea   <= wea;
            r_addr  <= addr[31:2];
            r_wdata <= wdata;
            r_cnt   <= CNT_INIT;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_rdata <= w_in_range ? w_merged : 32'd0;
            r_err   <= ~w_in_range;
            r_state <= S_ACK;
          end
        end
        S_ACK: begin
          r_err   <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_err   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Array write on the commit edge, suppressed while reset is asserted or the address is out of range.
  always_ff @(posedge clk) begin
    if (rst_n && w_commit && w_in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (r_wea[i]) r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
      end
    end
  end

  assign rdata = r_rdata;
  assign ack   = (r_state == S_ACK);
  assign busy  = (r_state != S_IDLE);
  assign err   = r_err;

endmodule

// File: tb/tb_dm_responder.sv
// Directed self-checking bench for dm_responder (WAIT_CYCLES = 2, 1 and 15).
module tb_dm_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, req1, req15;
  logic [3:0]  wea;
  logic [31:0] addr, wdata;

  logic [31:0] rdata, rdata1, rdata15;
  logic        ack, ack1, ack15;
  logic        err, err1, err15;
  logic        busy, busy1, busy15;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dm_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .wea(wea), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ack(ack), .err(err), .busy(busy));

  dm_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .wea(wea), .addr(addr), .wdata(wdata),
    .rdata(rdata1), .ack(ack1), .err(err1), .busy(busy1));

  dm_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(15)) u_dut15 (
    .clk(clk), .rst_n(rst_n), .req(req15), .wea(wea), .addr(addr), .wdata(wdata),
    .rdata(rdata15), .ack(ack15), .err(err15), .busy(busy15));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction on the WAIT_CYCLES=2 instance, checked for latency and response.
  task automatic txn(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] exp_rd, input logic exp_err, input string tag);
    int n;
    @(negedge clk); req = 1'b1; wea = w; addr = a; wdata = d;
    @(negedge clk); req = 1'b0;
    chk({tag, "_busy_after_accept"}, 32'(busy), 32'd1);
    n = 0;
    while (!ack && n < 40) begin
      @(negedge clk); n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'd2);
    chk({tag, "_rdata"},   rdata, exp_rd);
    chk({tag, "_err"},     32'(err), 32'(exp_err));
    chk({tag, "_busy_ack"}, 32'(busy), 32'd1);
    @(negedge clk);
    chk({tag, "_ack_drop"}, {29'd0, ack, busy, err}, 32'd0);
    chk({tag, "_rdata_hold"}, rdata, exp_rd);
  endtask

  initial begin
    int n;
    int acks;
    rst_n = 1'b0; req = 1'b0; req1 = 1'b0; req15 = 1'b0;
    wea = 4'd0; addr = 32'd0; wdata = 32'd0;
    repeat (3) @(negedge clk);
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_flags", {29'd0, ack, err, busy}, 32'd0);
    chk("reset_dut15", {rdata15[28:0], ack15, err15, busy15}, 32'd0);
    rst_n = 1'b1;

    // 1. word write then read
    txn(4'b1111, 32'h10, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, "t1_wr");
    txn(4'b0000, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, "t1_rd");

    // 2. partial lanes
    txn(4'b1111, 32'h20, 32'h11223344, 32'h11223344, 1'b0, "t2_pre");
    txn(4'b0011, 32'h20, 32'hAAAABBBB, 32'h1122BBBB, 1'b0, "t2_lo16");
    txn(4'b0001, 32'h20, 32'h000000CC, 32'h1122BBCC, 1'b0, "t2_lane0");
    txn(4'b0000, 32'h20, 32'hFFFFFFFF, 32'h1122BBCC, 1'b0, "t2_rd");

    // 3. out of range, aliasing onto index 0
    txn(4'b1111, 32'h0,    32'hCAFEF00D, 32'hCAFEF00D, 1'b0, "t3_pre");
    txn(4'b1111, 32'h1000, 32'h55555555, 32'h0,        1'b1, "t3_oor");
    txn(4'b0000, 32'h0,    32'h0,        32'hCAFEF00D, 1'b0, "t3_rd");

    // 4. requests during WAIT/ACK ignored; held req accepted after ACK
    @(negedge clk); req = 1'b1; wea = 4'b1111; addr = 32'h40; wdata = 32'hA1A1A1A1;
    @(negedge clk); addr = 32'h44; wdata = 32'hB2B2B2B2; acks = int'(ack);
    @(negedge clk); acks += int'(ack);
    @(negedge clk); acks += int'(ack);
    chk("t4_first_rdata", rdata, 32'hA1A1A1A1);
    @(negedge clk); acks += int'(ack);
    chk("t4_single_ack", 32'(acks), 32'd1);
    chk("t4_idle_gap", 32'(busy), 32'd0);
    @(negedge clk);
    chk("t4_reaccept", 32'(busy), 32'd1);
    req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t4_second_ack", 32'(ack), 32'd1);
    chk("t4_second_rdata", rdata, 32'hB2B2B2B2);
    @(negedge clk);
    txn(4'b0000, 32'h40, 32'h0, 32'hA1A1A1A1, 1'b0, "t4_rd40");
    txn(4'b0000, 32'h44, 32'h0, 32'hB2B2B2B2, 1'b0, "t4_rd44");

    // 5. reset mid-WAIT aborts the write
    txn(4'b1111, 32'h30, 32'h0,        32'h0,        1'b0, "t5_pre");
    txn(4'b0000, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, "t5_rdnz");
    @(negedge clk); req = 1'b1; wea = 4'b1111; addr = 32'h30; wdata = 32'h12345678;
    @(negedge clk); req = 1'b0; rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    chk("t5_rst_rdata", rdata, 32'd0);
    chk("t5_rst_flags", {29'd0, ack, err, busy}, 32'd0);
    acks = 0;
    repeat (4) begin
      @(negedge clk); acks += int'(ack);
    end
    chk("t5_no_ack", 32'(acks), 32'd0);
    txn(4'b0000, 32'h30, 32'h0, 32'h0, 1'b0, "t5_rd30");

    // 6a. WAIT_CYCLES = 1
    @(negedge clk); req1 = 1'b1; wea = 4'b1111; addr = 32'h8; wdata = 32'h5A5A5A5A;
    @(negedge clk); req1 = 1'b0;
    n = 0;
    while (!ack1 && n < 40) begin
      @(negedge clk); n++;
    end
    chk("t6_wc1_latency", 32'(n), 32'd1);
    chk("t6_wc1_rdata", rdata1, 32'h5A5A5A5A);
    @(negedge clk);
    chk("t6_wc1_drop", {30'd0, ack1, busy1}, 32'd0);

    // 6b. WAIT_CYCLES = 15
    @(negedge clk); req15 = 1'b1; wea = 4'b0110; addr = 32'h8; wdata = 32'h00C3C300;
    @(negedge clk); req15 = 1'b0;
    n = 0;
    while (!ack15 && n < 40) begin
      @(negedge clk); n++;
    end
    chk("t6_wc15_latency", 32'(n), 32'd15);
    chk("t6_wc15_err", 32'(err15), 32'd0);
    @(negedge clk);
    chk("t6_wc15_drop", {30'd0, ack15, busy15}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Data-memory responder sitting behind the CPU-side data-memory controller.
- Accepts one request at a time: per-lane write-enable, byte address and write data.
- Models a configurable number of wait states, then commits byte-lane writes to an internal word array and returns the full addressed word with a one-cycle ack.
- Lane selection and load extension stay in the controller; this block only honours the lane enables and returns raw 32-bit words.

Parameters:
ADDR_WIDTH, 10, number of word-index bits; array depth = 2**ADDR_WIDTH words, indexed by addr[ADDR_WIDTH+1:2].
WAIT_CYCLES, 2, wait states between accept and commit; legal range 1..15.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  synchronous active-low reset.
req  input  1  request strobe; sampled only in IDLE.
wea  input  4  byte-lane write enables; bit i writes wdata[8i+7:8i] to lane i; 4'b0000 = read.
addr  input  32  byte address; bits [1:0] ignored.
wdata  input  32  write data, lane-aligned (no shifting inside this block).
rdata  output  32  registered word returned with ack.
ack  output  1  one-cycle completion pulse.
err  output  1  out-of-range flag; valid only while ack=1.
busy  output  1  high from the accept edge until ack deasserts.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE, wait counter=0, rdata=32'h0, ack=0, err=0, busy=0, captured request registers cleared.
  - Array contents are not reset.
- FSM states:
  - IDLE:
    - busy=0, ack=0.
    - If req=1 at edge k, capture wea/addr/wdata, load counter with WAIT_CYCLES-1, go to WAIT.
    - busy is 1 from edge k.
  - WAIT:
    - busy=1.
    - Each edge: if counter!=0, decrement; if counter==0, commit and go to ACK.
  - ACK:
    - ack=1, busy=1 for exactly one cycle.
    - Next edge returns to IDLE, deasserting ack, err and busy.
- Latency: request accepted at edge k gives ack high in the cycle after edge k+WAIT_CYCLES. Throughput is one transaction per WAIT_CYCLES+2 cycles.
- Commit (edge WAIT→ACK):
  - In range (addr[31:ADDR_WIDTH+2]==0):
    - Each lane with wea[i]=1 is overwritten with the captured wdata lane.
    - rdata = merged word: new lanes where wea=1, old lanes elsewhere. A read (wea=0) returns the stored word.
    - err=0.
  - Out of range: no array write, rdata=32'h0, err=1.
- Input handling:
  - req, wea, addr and wdata are ignored outside IDLE.
  - Inputs changing after accept have no effect; only the captured values are used.
- Continuous req: a req held high in IDLE starts a new transaction immediately. There is no back-to-back accept during ACK.
- rdata holds its value after ack until the next commit; err clears when leaving ACK.
- Reset mid-operation:
  - Reset asserted in WAIT before the commit edge aborts the transaction with no array write.
  - Reset on the commit edge itself also suppresses the write (reset has priority).
- Read-after-write to the same word, in consecutive transactions, returns the updated data.

Test Plan:
1. Word write/read, WAIT_CYCLES=2:
   - Stimulus: req at edge 0 with wea=4'b1111, addr=32'h10, wdata=32'hDEADBEEF.
   - Response: ack high after edge 2, busy 1 from edge 0 through ack, rdata=32'hDEADBEEF, err=0.
   - Follow-up: read of addr=32'h10 returns 32'hDEADBEEF.
2. Partial lanes:
   - Pre-load 32'h11223344 at addr 32'h20.
   - Write wea=4'b0011, wdata=32'hAAAABBBB → rdata=32'h1122BBBB.
   - Write wea=4'b0001, wdata=32'h000000CC → rdata=32'h1122BBCC; a subsequent read confirms it.
3. Out of range (ADDR_WIDTH=10):
   - Stimulus: write to addr=32'h00001000.
   - Response: ack with err=1, rdata=0.
   - Follow-up: read of addr=32'h0 shows the previously written word unchanged.
4. Busy rejection:
   - Stimulus: second req with different addr/wdata asserted during WAIT and ACK.
   - Response: ignored, only one ack; with req then held high, the next transaction is accepted in the IDLE cycle after ACK.
5. Reset mid-WAIT:
   - Stimulus: rst_n=0 for one edge after accepting a write of 32'h12345678 to addr 32'h30 (which holds 32'h0).
   - Response: outputs return to reset values; a later read of addr 32'h30 returns 32'h0.
6. WAIT_CYCLES=1 and 15:
   - Response: ack appears exactly 1 and 15 edges after the accept edge, respectively.
